// File: rtl/reg_bank_wb_pkg.sv
// Shared MIPS datapath definitions: register-index constants, widths and the
// write-port bundle used by the register bank and the reg-dest mux.
package mips_defs;

  localparam int DATA_W       = 32;
  localparam int REGIDX_W     = 5;
  localparam int NREGS_DEF    = 32;
  localparam int WRCNT_W      = 8;
  localparam int SP_RESET_DEF = 227;

  localparam logic [REGIDX_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REGIDX_W-1:0] REG_SP   = 5'd29;
  localparam logic [REGIDX_W-1:0] REG_RA   = 5'd31;

  typedef logic [DATA_W-1:0]   word_t;
  typedef logic [REGIDX_W-1:0] regidx_t;

  // A write that will actually commit at the next rising edge.
  typedef struct packed {
    logic    en;
    regidx_t idx;
    word_t   data;
  } wr_port_t;

  // $0 is hard-wired; nothing may ever land in it.
  function automatic logic is_zero_reg(input regidx_t idx);
    return idx == REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_bank_wb_rdport.sv
// One asynchronous read port of the register bank. Applies the $0 rule and,
// when BYPASS=1, forwards a same-cycle committing write to the reader.
module reg_bank_rdport
  import mips_defs::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter bit BYPASS = 1'b1
) (
  input  logic [REGIDX_W-1:0]          idx,
  input  logic [NREGS-1:0][DATA_W-1:0] bank,
  input  wr_port_t                     wr,
  output logic [DATA_W-1:0]            data
);

  logic hit;

  // Forwarding hit: the committing write targets the register being read.
  assign hit = BYPASS && wr.en && (wr.idx == idx);

  // Read mux: $0 wins over everything, then bypass, then stored value.
  // NOTE: every path assigns data after a default, so no latch is inferred.
  always_comb begin
    data = '0;
    if (!is_zero_reg(idx)) begin
      if (hit) data = wr.data;
      else     data = bank[idx];
    end
  end

endmodule

// File: rtl/reg_bank_wb.sv
// 32 x 32-bit MIPS general-purpose register bank: two asynchronous read ports,
// one synchronous write port, saturating committed-write counter.
module reg_bank_wb
  import mips_defs::*;
#(
  parameter int SP_RESET = SP_RESET_DEF,
  parameter bit BYPASS   = 1'b1,
  parameter int NREGS    = NREGS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reg_write,
  input  logic [REGIDX_W-1:0] write_reg,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [REGIDX_W-1:0] read_reg1,
  input  logic [REGIDX_W-1:0] read_reg2,
  output logic [DATA_W-1:0]   read_data1,
  output logic [DATA_W-1:0]   read_data2,
  output logic [WRCNT_W-1:0]  wr_count
);

  logic [NREGS-1:0][DATA_W-1:0] bank;
  wr_port_t                     wr;

  // A write commits only outside reset and never to $0.
  assign wr.en   = reg_write && !reset && !is_zero_reg(write_reg);
  assign wr.idx  = write_reg;
  assign wr.data = write_data;

  // Storage array: reset to all-zero except $sp, then one write per cycle.
  // NOTE: this bank is a flop array with a defined reset image, so every entry
  // is reset explicitly; it must not be mapped onto a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        if (i == int'(REG_SP)) bank[i] <= DATA_W'(SP_RESET);
        else                   bank[i] <= '0;
      end
    end else if (wr.en) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of process ordering.
      bank[wr.idx] <= wr.data;
    end
  end

  // Committed-write counter, saturating at all-ones, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)                      wr_count <= '0;
    else if (wr.en && !(&wr_count)) wr_count <= wr_count + 1'b1;
  end

  reg_bank_rdport #(.NREGS(NREGS), .BYPASS(BYPASS)) u_rd1 (
    .idx  (read_reg1),
    .bank (bank),
    .wr   (wr),
    .data (read_data1)
  );

  reg_bank_rdport #(.NREGS(NREGS), .BYPASS(BYPASS)) u_rd2 (
    .idx  (read_reg2),
    .bank (bank),
    .wr   (wr),
    .data (read_data2)
  );

endmodule

// File: tb/tb_reg_bank_wb.sv
// Self-checking bench for reg_bank_wb: one instance with BYPASS=1 and one with
// BYPASS=0 share every input; both are compared to a behavioural model.
module tb_reg_bank_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic [7:0]  cnt_b, cnt_n;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: plain array of register contents plus a commit count.
  logic [31:0] model_regs [32];
  int          model_cnt;

  always #5 clk = ~clk;

  reg_bank_wb #(.SP_RESET(227), .BYPASS(1'b1), .NREGS(32)) dut_b (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_b), .read_data2(rd2_b), .wr_count(cnt_b)
  );

  reg_bank_wb #(.SP_RESET(227), .BYPASS(1'b0), .NREGS(32)) dut_n (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_n), .read_data2(rd2_n), .wr_count(cnt_n)
  );

  // What a reader of idx should see right now, given the current inputs.
  function automatic logic [31:0] model_read(input logic [4:0] idx, input bit bypass);
    if (idx == 5'd0) return 32'd0;
    if (bypass && !reset && reg_write && write_reg == idx) return write_data;
    return model_regs[idx];
  endfunction

  // Apply the architectural effect of the current inputs, then cross the edge.
  task automatic tick();
    if (reset) begin
      foreach (model_regs[i]) model_regs[i] = (i == 29) ? 32'd227 : 32'd0;
      model_cnt = 0;
    end else if (reg_write && write_reg != 5'd0) begin
      model_regs[write_reg] = write_data;
      if (model_cnt < 255) model_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp1, exp2;
    reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = '0; read_reg2 = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(31 - i);
      #2;
      exp1 = (i == 29) ? 32'd227 : 32'd0;
      exp2 = ((31 - i) == 29) ? 32'd227 : 32'd0;
      n_checks++;
      if (rd1_b !== exp1 || rd1_n !== exp1) begin
        n_fail++;
        $display("FAIL reset_rd1 idx=%0d got b=%h n=%h expected %h", i, rd1_b, rd1_n, exp1);
      end
      n_checks++;
      if (rd2_b !== exp2 || rd2_n !== exp2) begin
        n_fail++;
        $display("FAIL reset_rd2 idx=%0d got b=%h n=%h expected %h", 31 - i, rd2_b, rd2_n, exp2);
      end
    end
    n_checks++;
    if (cnt_b !== 8'd0 || cnt_n !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_count got b=%0d n=%0d expected 0", cnt_b, cnt_n);
    end
  endtask

  task automatic test_write_readback();
    reg_write = 1'b1; write_reg = 5'd8;  write_data = 32'hDEADBEEF; tick();
    reg_write = 1'b1; write_reg = 5'd31; write_data = 32'h12345678; tick();
    reg_write = 1'b0; read_reg1 = 5'd8; read_reg2 = 5'd31;
    #2;
    n_checks++;
    if (rd1_b !== 32'hDEADBEEF || rd1_n !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL readback_r8 got b=%h n=%h expected deadbeef", rd1_b, rd1_n);
    end
    n_checks++;
    if (rd2_b !== 32'h12345678 || rd2_n !== 32'h12345678) begin
      n_fail++;
      $display("FAIL readback_r31 got b=%h n=%h expected 12345678", rd2_b, rd2_n);
    end
    n_checks++;
    if (cnt_b !== 8'd2 || cnt_n !== 8'd2) begin
      n_fail++;
      $display("FAIL readback_count got b=%0d n=%0d expected 2", cnt_b, cnt_n);
    end
  endtask

  task automatic test_zero_protect();
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFFFFFF;
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    #2;
    n_checks++;
    if (rd1_b !== 32'd0 || rd2_b !== 32'd0 || rd1_n !== 32'd0 || rd2_n !== 32'd0) begin
      n_fail++;
      $display("FAIL zero_same_cycle got b=%h/%h n=%h/%h expected 0", rd1_b, rd2_b, rd1_n, rd2_n);
    end
    tick();
    reg_write = 1'b0;
    #2;
    n_checks++;
    if (rd1_b !== 32'd0 || rd2_n !== 32'd0) begin
      n_fail++;
      $display("FAIL zero_after got b=%h n=%h expected 0", rd1_b, rd2_n);
    end
    n_checks++;
    if (cnt_b !== 8'd2 || cnt_n !== 8'd2) begin
      n_fail++;
      $display("FAIL zero_count got b=%0d n=%0d expected 2", cnt_b, cnt_n);
    end
  endtask

  task automatic test_bypass();
    reg_write = 1'b1; write_reg = 5'd5; write_data = 32'h11111111; tick();
    reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hA5A5A5A5;
    read_reg1 = 5'd5; read_reg2 = 5'd5;
    #2;
    n_checks++;
    if (rd1_b !== 32'hA5A5A5A5 || rd2_b !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL bypass_on got %h/%h expected a5a5a5a5", rd1_b, rd2_b);
    end
    n_checks++;
    if (rd1_n !== 32'h11111111 || rd2_n !== 32'h11111111) begin
      n_fail++;
      $display("FAIL bypass_off got %h/%h expected 11111111", rd1_n, rd2_n);
    end
    tick();
    reg_write = 1'b0;
    #2;
    n_checks++;
    if (rd1_n !== 32'hA5A5A5A5 || rd2_n !== 32'hA5A5A5A5 || rd1_b !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL bypass_next got n=%h/%h b=%h expected a5a5a5a5", rd1_n, rd2_n, rd1_b);
    end
  endtask

  task automatic test_reset_collision();
    reset = 1'b1; reg_write = 1'b1; write_reg = 5'd29; write_data = 32'd7;
    read_reg1 = 5'd29; read_reg2 = 5'd5;
    #2;
    n_checks++;
    if (rd1_b !== 32'd227) begin
      n_fail++;
      $display("FAIL collision_no_bypass got %h expected %h", rd1_b, 32'd227);
    end
    tick();
    reset = 1'b0; reg_write = 1'b0;
    #2;
    n_checks++;
    if (rd1_b !== 32'd227 || rd1_n !== 32'd227) begin
      n_fail++;
      $display("FAIL collision_sp got b=%h n=%h expected %h", rd1_b, rd1_n, 32'd227);
    end
    n_checks++;
    if (rd2_b !== 32'd0) begin
      n_fail++;
      $display("FAIL collision_r5 got %h expected 0", rd2_b);
    end
    n_checks++;
    if (cnt_b !== 8'd0 || cnt_n !== 8'd0) begin
      n_fail++;
      $display("FAIL collision_count got b=%0d n=%0d expected 0", cnt_b, cnt_n);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1b, e2b, e1n, e2n;
    for (int c = 0; c < 400; c++) begin
      reg_write  = ($urandom_range(0, 3) != 0);
      write_reg  = 5'($urandom_range(0, 31));
      write_data = $urandom;
      read_reg1  = ($urandom_range(0, 2) == 0) ? write_reg : 5'($urandom_range(0, 31));
      read_reg2  = ($urandom_range(0, 2) == 0) ? read_reg1 : 5'($urandom_range(0, 31));
      #2;
      e1b = model_read(read_reg1, 1'b1); e2b = model_read(read_reg2, 1'b1);
      e1n = model_read(read_reg1, 1'b0); e2n = model_read(read_reg2, 1'b0);
      n_checks++;
      if (rd1_b !== e1b || rd2_b !== e2b) begin
        n_fail++;
        $display("FAIL rand_bypass cyc=%0d r%0d/r%0d got %h/%h expected %h/%h",
                 c, read_reg1, read_reg2, rd1_b, rd2_b, e1b, e2b);
      end
      n_checks++;
      if (rd1_n !== e1n || rd2_n !== e2n) begin
        n_fail++;
        $display("FAIL rand_nobypass cyc=%0d r%0d/r%0d got %h/%h expected %h/%h",
                 c, read_reg1, read_reg2, rd1_n, rd2_n, e1n, e2n);
      end
      n_checks++;
      if (int'(cnt_b) != model_cnt || int'(cnt_n) != model_cnt) begin
        n_fail++;
        $display("FAIL rand_count cyc=%0d got b=%0d n=%0d expected %0d", c, cnt_b, cnt_n, model_cnt);
      end
      tick();
    end
    reg_write = 1'b0;
  endtask

  task automatic test_saturation();
    logic [31:0] last = '0;
    for (int k = 0; k < 300; k++) begin
      reg_write = 1'b1; write_reg = 5'd1; write_data = $urandom; last = write_data;
      tick();
    end
    reg_write = 1'b0; read_reg1 = 5'd1; read_reg2 = 5'd1;
    #2;
    n_checks++;
    if (cnt_b !== 8'hFF || cnt_n !== 8'hFF) begin
      n_fail++;
      $display("FAIL sat_count got b=%h n=%h expected ff", cnt_b, cnt_n);
    end
    n_checks++;
    if (rd1_b !== last || rd2_n !== last) begin
      n_fail++;
      $display("FAIL sat_data got b=%h n=%h expected %h", rd1_b, rd2_n, last);
    end
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_zero_protect();
    test_bypass();
    test_reset_collision();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
